// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   IMEM_BYTES_DEF     : default instruction-memory size in bytes
//   TIMEOUT_CYCLES_DEF : default idle-cycle limit between received bytes
//   state_e            : loader FSM state encoding
package loader_pkg;

  localparam int IMEM_BYTES_DEF     = 2048;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/loader_gap_timer.sv
// Idle-gap timer for the byte receiver.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count (has priority over enable)
//   enable       : count one idle cycle
//   expired      : this enabled cycle is the TIMEOUT_CYCLES-th idle cycle
module loader_gap_timer #(
  parameter int TIMEOUT_CYCLES = loader_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Flagged combinationally so the FSM leaves RECV on the very edge where
  // the count would reach TIMEOUT_CYCLES.
  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives a little-endian byte stream, assembles 32-bit
// words and writes them to instruction memory, holding the core in reset
// until the whole program has been loaded.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, word_count     : begin a load of word_count words
//   byte_valid/byte_data  : incoming byte stream
//   byte_ready            : loader can take a byte this cycle
//   imem_wr_en/addr/wdata : instruction-memory write port
//   core_reset_n          : datapath reset, released only after a good load
//   busy, done, error     : load status
//   dbg_state_o           : current FSM state (state_e encoding)
//
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready
// are both 1; byte_ready depends only on state, never on byte_valid, and
// the sender must hold byte_data stable while byte_valid is high and
// byte_ready is low.
module inst_loader
  import loader_pkg::*;
#(
  parameter int IMEM_BYTES     = IMEM_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_wr_en,
  output logic [10:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state_o
);

  localparam int MAX_WORDS = IMEM_BYTES / 4;

  state_e      state_q, state_d;
  logic [9:0]  count_q, count_d;
  logic [8:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;

  logic accept;
  logic gap_clear;
  logic gap_enable;
  logic gap_expired;

  assign accept = (state_q == RECV) && byte_valid;

  // Timer restarts whenever RECV is entered and after every accepted byte.
  assign gap_clear  = accept || ((state_q != RECV) && (state_d == RECV));
  assign gap_enable = (state_q == RECV) && !accept;

  loader_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (gap_clear),
    .enable (gap_enable),
    .expired(gap_expired)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (word_count == 10'd0) begin
            state_d = DONE;
          end else if ({22'd0, word_count} > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            count_d    = word_count;
            word_idx_d = '0;
            byte_idx_d = '0;
            state_d    = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end else if (gap_expired) begin
          // Any partially assembled word is simply abandoned here.
          state_d = ERR;
        end
      end
      WRITE: begin
        if (({1'b0, word_idx_q} + 10'd1) == count_q) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + 9'd1;
          byte_idx_d = '0;
          state_d    = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  // Outputs decode the state register only, so an asynchronous reset drives
  // them to their idle values immediately.
  assign byte_ready   = (state_q == RECV);
  assign imem_wr_en   = (state_q == WRITE);
  assign imem_addr    = (state_q == WRITE) ? {word_idx_q, 2'b00} : 11'd0;
  assign imem_wdata   = (state_q == WRITE) ? word_q : 32'd0;
  assign core_reset_n = (state_q == DONE);
  assign busy         = (state_q == RECV) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign dbg_state_o  = state_q;

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter IMEM_BYTES, default 2048: instruction-memory size in bytes; the loader supports at most IMEM_BYTES/4 words.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum idle cycles allowed between accepted bytes while receiving.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a program load.
REQ-006 Port word_count, input, 10: number of 32-bit words to load; sampled in the start cycle.
REQ-007 Port byte_valid, input, 1: byte_data carries a valid byte.
REQ-008 Port byte_data, input, 8: program byte stream, little-endian within each word.
REQ-009 Port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-010 Port imem_wr_en, output, 1: instruction-memory write strobe.
REQ-011 Port imem_addr, output, 11: instruction-memory byte address, always word-aligned.
REQ-012 Port imem_wdata, output, 32: assembled instruction word.
REQ-013 Port core_reset_n, output, 1: reset to the datapath, held low (active) until a load completes.
REQ-014 Port busy, output, 1: a load is in progress.
REQ-015 Port done, output, 1: last load completed successfully.
REQ-016 Port error, output, 1: last load aborted.

Function
REQ-017 The FSM SHALL use the states IDLE, RECV, WRITE, DONE and ERR.
REQ-018 A byte SHALL transfer only in a cycle where byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 only in RECV.
REQ-020 IDLE/DONE/ERR with start=1: if word_count=0, go to DONE; if word_count>IMEM_BYTES/4, go to ERR; otherwise latch the count, clear the word index and byte index, and go to RECV.
REQ-021 RECV: the k-th accepted byte of a word (k=0..3) SHALL be placed in bits [8k+7:8k] of the word; after the 4th accepted byte, go to WRITE.
REQ-022 WRITE: for exactly one cycle, imem_wr_en=1, imem_addr=word_index*4 and imem_wdata=the assembled word.
REQ-023 On leaving WRITE: go to DONE if word_index+1 equals the latched count; otherwise increment word_index, clear the byte index, and return to RECV.
REQ-024 Gap counter: clears on entry to RECV and on every accepted byte, increments on every other RECV cycle, and on reaching TIMEOUT_CYCLES moves the FSM to ERR.
REQ-025 Transfers from accepted bytes SHALL be 1 cycle each; a word SHALL take a minimum of 5 cycles (4 RECV + 1 WRITE).
REQ-026 start SHALL be ignored in RECV and WRITE.
REQ-027 byte_valid SHALL be ignored outside RECV.
REQ-028 core_reset_n=1 only in DONE.
REQ-029 busy=1 in RECV and WRITE.
REQ-030 done=1 in DONE.
REQ-031 error=1 in ERR.
REQ-032 imem_wr_en SHALL be 0 in every state except WRITE.
REQ-033 Starting a new load from DONE SHALL drive core_reset_n low again in the next cycle.
REQ-034 A partial word pending at a timeout SHALL be discarded, never written.

Reset
REQ-035 While reset_n=0: state IDLE, all counters 0, and outputs byte_ready=0, imem_wr_en=0, imem_addr=0, imem_wdata=0, core_reset_n=0, busy=0, done=0, error=0.
REQ-036 Assertion of reset_n mid-load SHALL abort immediately with no further memory writes.
REQ-037 Release of reset_n SHALL take effect on the first clock edge after deassertion.

Structure
REQ-038 The state enum and the IMEM_BYTES and TIMEOUT_CYCLES defaults SHALL live in the shared package loader_pkg.
REQ-039 The gap counter SHALL be a sub-module loader_gap_timer with clear, enable and expired ports.
REQ-040 Word assembly and the FSM SHALL reside in inst_loader.

Verification
REQ-041 Load word_count=2, bytes 13,00,00,00,93,00,10,00 with byte_valid held high -> imem writes 0x00000013 @0x000 and 0x00100093 @0x004; core_reset_n rises 1 cycle after the second write.
REQ-042 Same stream with byte_valid low for 3 cycles between each byte -> identical writes, no error.
REQ-043 word_count=1, 2 bytes sent, then idle TIMEOUT_CYCLES cycles -> error=1, no imem_wr_en pulse, core_reset_n stays 0.
REQ-044 start with word_count=0 -> done=1 in the next cycle, no writes; with word_count=513 -> error=1.
REQ-045 reset_n pulsed low after 6 bytes of a 3-word load -> exactly one write observed, all outputs return to reset values asynchronously.
REQ-046 Load 512 words -> last write at imem_addr=0x7FC, no address wrap, done=1.
